// File: rtl/bp_counter_table.sv
// Direct-mapped table of saturating counters with a power-up clear sweep; predicts in ID, resolves and trains in ME.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module bp_counter_table #(
  parameter int unsigned         INDEX_BITS = 10,
  parameter int unsigned         CNT_BITS   = 2,
  parameter logic [CNT_BITS-1:0] RESET_CNT  = 2'b10,
  parameter int unsigned         STAT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  output logic              pred_taken,
  output logic              ready,
  input  logic              me_valid,
  input  logic [31:0]       me_pc,
  input  logic              me_taken,
  input  logic [31:0]       me_target,
  input  logic              me_pred_taken,
  output logic              mispredict,
  output logic [31:0]       correct_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_misses
);

  localparam int unsigned         DEPTH   = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
  logic [CNT_BITS-1:0]     cnt_mem [DEPTH];

  logic [INDEX_BITS-1:0]   id_idx, me_idx, wr_idx;
  logic [CNT_BITS-1:0]     id_cnt, me_cnt, train_cnt, wr_data;
  logic                    wr_en;
  logic                    unused_pc_bits;

  assign id_idx         = id_pc[INDEX_BITS+1:2];
  assign me_idx         = me_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{id_pc[31:INDEX_BITS+2], id_pc[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + INDEX_BITS'(1);
        if (ptr_q == '1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    id_cnt     = cnt_mem[id_idx];
    ready      = (state_q == RUN);
    pred_taken = ready & id_valid & id_cnt[CNT_BITS-1];
    mispredict = ready & me_valid & (me_pred_taken != me_taken);
    correct_pc = (me_valid && me_taken) ? me_target : me_pc + 32'd4;
  end

  always_comb begin
    me_cnt = cnt_mem[me_idx];
    if (me_taken) train_cnt = (me_cnt == CNT_MAX) ? me_cnt : me_cnt + CNT_BITS'(1);
    else          train_cnt = (me_cnt == '0)      ? me_cnt : me_cnt - CNT_BITS'(1);
  end

  // Single write port: the clear sweep owns it during CLEAR, ME training during RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = RESET_CNT;
    if (state_q == CLEAR) begin
      wr_en = 1'b1;
    end else if (me_valid) begin
      wr_en   = 1'b1;
      wr_idx  = me_idx;
      wr_data = train_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) cnt_mem[wr_idx] <= wr_data;
  end

`ifdef BP_STATS_EN
  logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0] stat_misses_q, stat_misses_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_misses_d   = stat_misses_q;
    if (ready && me_valid && stat_branches_q != '1) stat_branches_d = stat_branches_q + STAT_W'(1);
    if (mispredict && stat_misses_q != '1)          stat_misses_d   = stat_misses_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_misses_q   <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_misses_q   <= stat_misses_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_misses   = stat_misses_q;
`else
  assign stat_branches = '0;
  assign stat_misses   = '0;
`endif

endmodule

// File: tb/tb_bp_counter_table.sv
// Scoreboard bench for bp_counter_table (16-entry table, 4-bit stats); stats expectations follow BP_STATS_EN.
module tb_bp_counter_table;

  localparam int unsigned IB    = 4;
  localparam int unsigned SW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int          SMAX  = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic          pred_taken;
  logic          ready;
  logic          me_valid;
  logic [31:0]   me_pc;
  logic          me_taken;
  logic [31:0]   me_target;
  logic          me_pred_taken;
  logic          mispredict;
  logic [31:0]   correct_pc;
  logic [SW-1:0] stat_branches;
  logic [SW-1:0] stat_misses;

  always #5 clk = ~clk;

  bp_counter_table #(
    .INDEX_BITS(IB),
    .CNT_BITS  (2),
    .RESET_CNT (2'b10),
    .STAT_W    (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .pred_taken   (pred_taken),
    .ready        (ready),
    .me_valid     (me_valid),
    .me_pc        (me_pc),
    .me_taken     (me_taken),
    .me_target    (me_target),
    .me_pred_taken(me_pred_taken),
    .mispredict   (mispredict),
    .correct_pc   (correct_pc),
    .stat_branches(stat_branches),
    .stat_misses  (stat_misses)
  );

  typedef struct {
    string       name;
    logic        pred;
    logic        misp;
    logic [31:0] cpc;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   model_cnt[DEPTH];
  bit   model_run;
  int   model_br, model_ms;

  function automatic int exp_stat(input int v);
`ifdef BP_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Drive one cycle of ID/ME traffic; expectations use the model state before the coming edge.
  task automatic drive_cycle(input string nm, input logic iv, input logic [31:0] ipc,
                             input logic mv, input logic [31:0] mpc, input logic mt,
                             input logic [31:0] mtgt, input logic mp);
    exp_t e;
    int   ii, mi;
    id_valid = iv; id_pc = ipc;
    me_valid = mv; me_pc = mpc; me_taken = mt; me_target = mtgt; me_pred_taken = mp;
    ii = int'(ipc[IB+1:2]);
    mi = int'(mpc[IB+1:2]);
    e.name = nm;
    e.pred = model_run && iv && (model_cnt[ii] >= 2);
    e.misp = model_run && mv && (mp != mt);
    e.cpc  = (mv && mt) ? mtgt : mpc + 32'd4;
    exp_q.push_back(e);
    if (model_run && mv) begin
      if (mt && model_cnt[mi] < 3)       model_cnt[mi]++;
      else if (!mt && model_cnt[mi] > 0) model_cnt[mi]--;
      if (model_br < SMAX) model_br++;
      if (e.misp && model_ms < SMAX) model_ms++;
    end
  endtask

  task automatic model_clear();
    model_run = 1'b0;
    model_br  = 0;
    model_ms  = 0;
    for (int i = 0; i < int'(DEPTH); i++) model_cnt[i] = 2;
  endtask

  task automatic reset_to_run();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEPTH) @(negedge clk);
    model_run = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    drive_cycle("in_reset", 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b exp 0", ready); end
    tests_run++;
    if (pred_taken !== e.pred) begin tests_failed++; $display("FAIL reset_pred got %b exp %b", pred_taken, e.pred); end
    tests_run++;
    if (mispredict !== e.misp) begin tests_failed++; $display("FAIL reset_misp got %b exp %b", mispredict, e.misp); end
    tests_run++;
    if (correct_pc !== e.cpc) begin tests_failed++; $display("FAIL reset_cpc got %h exp %h", correct_pc, e.cpc); end
    tests_run++;
    if (stat_branches !== '0 || stat_misses !== '0) begin
      tests_failed++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_branches, stat_misses);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      #1;
      tests_run++;
      if (ready !== 1'b0) begin tests_failed++; $display("FAIL clear_ready cycle %0d got %b exp 0", i, ready); end
      @(negedge clk);
    end
    model_run = 1'b1;
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL ready_rise got %b exp 1", ready); end
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive_cycle("post_clear_lookup", 1'b1, 32'h1000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (pred_taken !== e.pred || pred_taken !== 1'b1) begin
        tests_failed++; $display("FAIL %s idx %0d got %b exp %b", e.name, i, pred_taken, e.pred);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic outcomes [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      drive_cycle("sat_lookup", 1'b1, 32'h40, 1'b1, 32'h40, outcomes[i], 32'h500, 1'b0);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (pred_taken !== e.pred) begin tests_failed++; $display("FAIL %s step %0d got %b exp %b", e.name, i, pred_taken, e.pred); end
      @(negedge clk);
    end
    drive_cycle("sat_final", 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if (pred_taken !== e.pred || model_cnt[0] != 0) begin
      tests_failed++; $display("FAIL %s got %b exp %b", e.name, pred_taken, e.pred);
    end
    @(negedge clk);
  endtask

  task automatic test_mispredict();
    exp_t e;
    logic        mvs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] pcs [5] = '{32'h100, 32'h100, 32'h100, 32'h300, 32'hFFFF_FFFC};
    logic        mts [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        mps [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] cps [5] = '{32'h200, 32'h104, 32'h200, 32'h304, 32'h0};
    logic        mss [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive_cycle("misp", 1'b0, 32'h0, mvs[i], pcs[i], mts[i], 32'h200, mps[i]);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (mispredict !== e.misp || mispredict !== mss[i]) begin
        tests_failed++; $display("FAIL %s_flag step %0d got %b exp %b", e.name, i, mispredict, mss[i]);
      end
      tests_run++;
      if (correct_pc !== e.cpc || correct_pc !== cps[i]) begin
        tests_failed++; $display("FAIL %s_pc step %0d got %h exp %h", e.name, i, correct_pc, cps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_collision();
    exp_t e;
    drive_cycle("coll_prep", 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    #1; void'(exp_q.pop_front()); @(negedge clk);
    drive_cycle("coll_prep", 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h0, 1'b0);
    #1; void'(exp_q.pop_front()); @(negedge clk);
    drive_cycle("collide", 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h0, 1'b0);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if (pred_taken !== e.pred || pred_taken !== 1'b0) begin
      tests_failed++; $display("FAIL %s got %b exp 0", e.name, pred_taken);
    end
    @(negedge clk);
    drive_cycle("after_collide", 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if (pred_taken !== e.pred || pred_taken !== 1'b1) begin
      tests_failed++; $display("FAIL %s got %b exp 1", e.name, pred_taken);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      drive_cycle("mid_prep", 1'b0, 32'h0, 1'b1, 32'h4 * 32'(i), 1'b0, 32'h0, 1'b1);
      #1; void'(exp_q.pop_front()); @(negedge clk);
    end
    drive_cycle("run_traffic", 1'b1, 32'h8, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    model_clear();
    #1; void'(exp_q.pop_front()); @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive_cycle("clear_traffic", 1'b1, 32'h4 * 32'(i), 1'b1, 32'h4 * 32'(i), 1'b0, 32'h0, 1'b1);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (ready !== 1'b0 || mispredict !== e.misp || pred_taken !== e.pred) begin
        tests_failed++;
        $display("FAIL %s cycle %0d ready/misp/pred got %b%b%b exp 0%b%b", e.name, i, ready, mispredict, pred_taken, e.misp, e.pred);
      end
      @(negedge clk);
    end
    model_run = 1'b1;
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL restart_ready got %b exp 1", ready); end
    tests_run++;
    if (stat_branches !== '0 || stat_misses !== '0) begin
      tests_failed++; $display("FAIL clear_stats got %0d/%0d exp 0/0", stat_branches, stat_misses);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive_cycle("restart_lookup", 1'b1, 32'h4 * 32'(i), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (pred_taken !== e.pred) begin tests_failed++; $display("FAIL %s idx %0d got %b exp %b", e.name, i, pred_taken, e.pred); end
      @(negedge clk);
    end
  endtask

  task automatic test_stats();
    reset_to_run();
    for (int i = 0; i < 10; i++) begin
      drive_cycle("stat10", 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h0, (i % 3 == 2) ? 1'b0 : 1'b1);
      #1; void'(exp_q.pop_front()); @(negedge clk);
    end
    drive_cycle("stat_idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1; void'(exp_q.pop_front());
    tests_run++;
    if (int'(stat_branches) != exp_stat(model_br) || model_br != 10) begin
      tests_failed++; $display("FAIL stat_branches10 got %0d exp %0d", stat_branches, exp_stat(10));
    end
    tests_run++;
    if (int'(stat_misses) != exp_stat(model_ms) || model_ms != 3) begin
      tests_failed++; $display("FAIL stat_misses3 got %0d exp %0d", stat_misses, exp_stat(3));
    end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive_cycle("stat20", 1'b0, 32'h0, 1'b1, 32'h24, 1'b0, 32'h0, 1'b1);
      #1; void'(exp_q.pop_front()); @(negedge clk);
    end
    drive_cycle("stat_idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1; void'(exp_q.pop_front());
    tests_run++;
    if (int'(stat_branches) != exp_stat(SMAX)) begin
      tests_failed++; $display("FAIL stat_branches_sat got %0d exp %0d", stat_branches, exp_stat(SMAX));
    end
    tests_run++;
    if (int'(stat_misses) != exp_stat(13)) begin
      tests_failed++; $display("FAIL stat_misses13 got %0d exp %0d", stat_misses, exp_stat(13));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] ipc, mpc;
    logic        mt, mp;
    for (int i = 0; i < 60; i++) begin
      ipc = 32'($urandom_range(0, 63)) << 2;
      mpc = 32'($urandom_range(0, 63)) << 2;
      mt  = 1'($urandom_range(0, 1));
      mp  = 1'($urandom_range(0, 1));
      drive_cycle("b2b", 1'b1, ipc, 1'($urandom_range(0, 1)), mpc, mt, 32'h9000 + ipc, mp);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (pred_taken !== e.pred || mispredict !== e.misp || correct_pc !== e.cpc) begin
        tests_failed++;
        $display("FAIL %s cycle %0d pred/misp/pc got %b %b %h exp %b %b %h", e.name, i, pred_taken, mispredict, correct_pc, e.pred, e.misp, e.cpc);
      end
      @(negedge clk);
    end
    drive_cycle("b2b_idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1; void'(exp_q.pop_front());
    tests_run++;
    if (int'(stat_branches) != exp_stat(model_br) || int'(stat_misses) != exp_stat(model_ms)) begin
      tests_failed++;
      $display("FAIL b2b_stats got %0d/%0d exp %0d/%0d", stat_branches, stat_misses, exp_stat(model_br), exp_stat(model_ms));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_pc = '0;
    me_valid = 1'b0; me_pc = '0; me_taken = 1'b0; me_target = '0; me_pred_taken = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_saturation();
    test_mispredict();
    test_collision();
    test_reset_mid_clear();
    test_stats();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
